alu_ctrl_seq: RTL and testbench

Control-side counterpart of the bit-sliced ALU. It decodes RISC-V OP / OP-IMM fields into the ALU control bundle (operacion, invert, carry-in) and registers that bundle. It also executes SLL/SRL/SRA itself as a multi-cycle iterative shifter, because the slice array does not implement those operations. It sits between the instruction decode stage and the ALU slice array, and uses a valid/ready handshake on the request side.

---
 rtl/alu_ctrl_seq_if.sv | 34 +++
 rtl/alu_ctrl_seq.sv | 206 ++++++++++++++++++++
 tb/tb_alu_ctrl_seq.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_ctrl_seq_if.sv
// Request/response bundle between the decode stage and alu_ctrl_seq.
// The decode stage uses the master modport; alu_ctrl_seq uses the slave modport.
interface alu_ctrl_seq_if #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
);
    logic               valid_i;
    logic               ready_o;
    logic [6:0]         opcode_i;
    logic [2:0]         funct3_i;
    logic               funct7b5_i;
    logic [WIDTH-1:0]   a_i;
    logic [SHAMT_W-1:0] shamt_i;
    logic [3:0]         operacion_o;
    logic               invert_o;
    logic               carry_o;
    logic               ctrl_valid_o;
    logic               illegal_o;
    logic [WIDTH-1:0]   shift_result_o;
    logic               shift_valid_o;
    logic               busy_o;

    modport master (
        output valid_i, opcode_i, funct3_i, funct7b5_i, a_i, shamt_i,
        input  ready_o, operacion_o, invert_o, carry_o, ctrl_valid_o,
               illegal_o, shift_result_o, shift_valid_o, busy_o
    );

    modport slave (
        input  valid_i, opcode_i, funct3_i, funct7b5_i, a_i, shamt_i,
        output ready_o, operacion_o, invert_o, carry_o, ctrl_valid_o,
               illegal_o, shift_result_o, shift_valid_o, busy_o
    );
endinterface

// File: rtl/alu_ctrl_seq.sv
// Decodes OP/OP-IMM into the registered ALU control bundle and runs
// SLL/SRL/SRA as a one-bit-per-cycle iterative shifter.
module alu_ctrl_seq #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    alu_ctrl_seq_if.slave bus
);
    localparam logic [6:0] OPC_R = 7'b0110011;
    localparam logic [6:0] OPC_I = 7'b0010011;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SLT  = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLTU = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sreg_q, sreg_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic               left_q, left_d;
    logic               arith_q, arith_d;
    logic [3:0]         op_q, op_d;
    logic               inv_q, inv_d;
    logic               cin_q, cin_d;
    logic               ctrl_valid_q, ctrl_valid_d;
    logic               illegal_q, illegal_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               shift_valid_q, shift_valid_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;

    logic               dec_legal;
    logic [3:0]         dec_op;
    logic               dec_inv;
    logic               dec_cin;
    logic               dec_shift;
    logic               dec_left;
    logic               dec_arith;
    logic               accept;
    logic [WIDTH-1:0]   sreg_step;

    // Instruction field decode; funct7b5 selects SUB only for R-type, SRA for both.
    always_comb begin
        dec_legal = (bus.opcode_i == OPC_R) || (bus.opcode_i == OPC_I);
        dec_op    = OP_AND;
        dec_inv   = 1'b0;
        dec_cin   = 1'b0;
        dec_shift = 1'b0;
        dec_left  = 1'b0;
        dec_arith = 1'b0;
        case (bus.funct3_i)
            3'b000: begin
                dec_op = OP_ADD;
                if ((bus.opcode_i == OPC_R) && bus.funct7b5_i) begin
                    dec_inv = 1'b1;
                    dec_cin = 1'b1;
                end
            end
            3'b010: begin
                dec_op  = OP_SLT;
                dec_inv = 1'b1;
                dec_cin = 1'b1;
            end
            3'b011: begin
                dec_op  = OP_SLTU;
                dec_inv = 1'b1;
                dec_cin = 1'b1;
            end
            3'b100: dec_op = OP_XOR;
            3'b110: dec_op = OP_OR;
            3'b111: dec_op = OP_AND;
            3'b001: begin
                dec_op    = OP_SLL;
                dec_shift = 1'b1;
                dec_left  = 1'b1;
            end
            3'b101: begin
                dec_shift = 1'b1;
                dec_arith = bus.funct7b5_i;
                dec_op    = bus.funct7b5_i ? OP_SRA : OP_SRL;
            end
            default: dec_op = OP_AND;
        endcase
    end

    assign accept    = bus.valid_i && (state_q == IDLE);
    assign sreg_step = left_q ? {sreg_q[WIDTH-2:0], 1'b0}
                              : {arith_q & sreg_q[WIDTH-1], sreg_q[WIDTH-1:1]};

    // Next-state and next-output logic.
    always_comb begin
        state_d       = state_q;
        sreg_d        = sreg_q;
        cnt_d         = cnt_q;
        left_d        = left_q;
        arith_d       = arith_q;
        op_d          = op_q;
        inv_d         = inv_q;
        cin_d         = cin_q;
        ctrl_valid_d  = 1'b0;
        illegal_d     = 1'b0;
        result_d      = result_q;
        shift_valid_d = 1'b0;
        ready_d       = 1'b0;
        busy_d        = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!dec_legal) begin
                        illegal_d = 1'b1;
                        op_d      = 4'b0000;
                        inv_d     = 1'b0;
                        cin_d     = 1'b0;
                    end else begin
                        op_d         = dec_op;
                        inv_d        = dec_inv;
                        cin_d        = dec_cin;
                        ctrl_valid_d = 1'b1;
                        if (dec_shift) begin
                            sreg_d  = bus.a_i;
                            cnt_d   = bus.shamt_i;
                            left_d  = dec_left;
                            arith_d = dec_arith;
                            state_d = (bus.shamt_i == '0) ? DONE : SHIFT;
                        end
                    end
                end
            end
            SHIFT: begin
                sreg_d = sreg_step;
                cnt_d  = cnt_q - SHAMT_W'(1);
                if (cnt_q == SHAMT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Result and status flops track the state being entered.
        if (state_d == DONE) begin
            shift_valid_d = 1'b1;
            result_d      = sreg_d;
        end
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= IDLE;
            sreg_q        <= '0;
            cnt_q         <= '0;
            left_q        <= 1'b0;
            arith_q       <= 1'b0;
            op_q          <= 4'b0000;
            inv_q         <= 1'b0;
            cin_q         <= 1'b0;
            ctrl_valid_q  <= 1'b0;
            illegal_q     <= 1'b0;
            result_q      <= '0;
            shift_valid_q <= 1'b0;
            ready_q       <= 1'b1;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            sreg_q        <= sreg_d;
            cnt_q         <= cnt_d;
            left_q        <= left_d;
            arith_q       <= arith_d;
            op_q          <= op_d;
            inv_q         <= inv_d;
            cin_q         <= cin_d;
            ctrl_valid_q  <= ctrl_valid_d;
            illegal_q     <= illegal_d;
            result_q      <= result_d;
            shift_valid_q <= shift_valid_d;
            ready_q       <= ready_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.ready_o        = ready_q;
    assign bus.busy_o         = busy_q;
    assign bus.operacion_o    = op_q;
    assign bus.invert_o       = inv_q;
    assign bus.carry_o        = cin_q;
    assign bus.ctrl_valid_o   = ctrl_valid_q;
    assign bus.illegal_o      = illegal_q;
    assign bus.shift_result_o = result_q;
    assign bus.shift_valid_o  = shift_valid_q;
endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed self-checking bench for alu_ctrl_seq; bundle checks compare
// {operacion, invert, carry} packed into the low 6 bits.
module tb_alu_ctrl_seq;
    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_I   = 7'b0010011;
    localparam logic [6:0] OPC_BAD = 7'b1100011;

    logic clk_i;
    logic rst_n_i;
    int   errors;
    int   checks;
    logic seen;

    alu_ctrl_seq_if #(.WIDTH(32), .SHAMT_W(5)) bus ();

    alu_ctrl_seq #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .bus     (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] bnd();
        return 32'({bus.operacion_o, bus.invert_o, bus.carry_o});
    endfunction

    task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                         input logic [31:0] a, input logic [4:0] sh);
        bus.valid_i    = 1'b1;
        bus.opcode_i   = opc;
        bus.funct3_i   = f3;
        bus.funct7b5_i = f7;
        bus.a_i        = a;
        bus.shamt_i    = sh;
    endtask

    // Accept one shift, then check the result appears exactly sh+1 cycles after accept.
    task automatic run_shift(input string tag, input logic [2:0] f3, input logic f7,
                             input logic [31:0] a, input logic [4:0] sh,
                             input logic [31:0] exp_bnd, input logic [31:0] exp_res);
        drive(OPC_R, f3, f7, a, sh);
        tick();
        bus.valid_i = 1'b0;
        chk({tag, "_bundle"}, bnd(), exp_bnd);
        chk({tag, "_ctrl_valid"}, 32'(bus.ctrl_valid_o), 32'd1);
        seen = 1'b0;
        repeat (int'(sh)) begin
            seen = seen | bus.shift_valid_o;
            tick();
        end
        chk({tag, "_early_valid"}, 32'(seen), 32'd0);
        chk({tag, "_shift_valid"}, 32'(bus.shift_valid_o), 32'd1);
        chk({tag, "_result"}, bus.shift_result_o, exp_res);
        tick();
        chk({tag, "_ready_back"}, 32'(bus.ready_o), 32'd1);
        chk({tag, "_valid_drop"}, 32'(bus.shift_valid_o), 32'd0);
    endtask

    logic [6:0]  t_opc [8];
    logic [2:0]  t_f3  [8];
    logic        t_f7  [8];
    logic [31:0] t_exp [8];

    initial begin
        errors = 0;
        checks = 0;
        rst_n_i = 1'b0;
        bus.valid_i = 1'b0;
        bus.opcode_i = '0;
        bus.funct3_i = '0;
        bus.funct7b5_i = 1'b0;
        bus.a_i = '0;
        bus.shamt_i = '0;
        repeat (2) tick();

        chk("rst_ready", 32'(bus.ready_o), 32'd1);
        chk("rst_busy", 32'(bus.busy_o), 32'd0);
        chk("rst_bundle", bnd(), 32'h00);
        chk("rst_ctrl_valid", 32'(bus.ctrl_valid_o), 32'd0);
        chk("rst_illegal", 32'(bus.illegal_o), 32'd0);
        chk("rst_shift_valid", 32'(bus.shift_valid_o), 32'd0);
        chk("rst_result", bus.shift_result_o, 32'h0);
        rst_n_i = 1'b1;
        tick();

        // ADD then SUB back-to-back
        drive(OPC_R, 3'b000, 1'b0, 32'h0, 5'd0);
        tick();
        chk("add_bundle", bnd(), 32'h08);
        chk("add_ctrl_valid", 32'(bus.ctrl_valid_o), 32'd1);
        bus.funct7b5_i = 1'b1;
        tick();
        chk("sub_bundle", bnd(), 32'h0B);
        chk("sub_ctrl_valid", 32'(bus.ctrl_valid_o), 32'd1);
        bus.valid_i = 1'b0;
        tick();
        chk("idle_ctrl_valid", 32'(bus.ctrl_valid_o), 32'd0);
        chk("idle_bundle_hold", bnd(), 32'h0B);

        // Remaining non-shift decodes, one per cycle
        t_opc[0] = OPC_I; t_f3[0] = 3'b010; t_f7[0] = 1'b0; t_exp[0] = 32'h0F;
        t_opc[1] = OPC_R; t_f3[1] = 3'b011; t_f7[1] = 1'b0; t_exp[1] = 32'h17;
        t_opc[2] = OPC_R; t_f3[2] = 3'b100; t_f7[2] = 1'b0; t_exp[2] = 32'h10;
        t_opc[3] = OPC_I; t_f3[3] = 3'b110; t_f7[3] = 1'b0; t_exp[3] = 32'h04;
        t_opc[4] = OPC_R; t_f3[4] = 3'b111; t_f7[4] = 1'b0; t_exp[4] = 32'h00;
        t_opc[5] = OPC_I; t_f3[5] = 3'b000; t_f7[5] = 1'b1; t_exp[5] = 32'h08;
        t_opc[6] = OPC_R; t_f3[6] = 3'b010; t_f7[6] = 1'b0; t_exp[6] = 32'h0F;
        t_opc[7] = OPC_I; t_f3[7] = 3'b100; t_f7[7] = 1'b0; t_exp[7] = 32'h10;
        for (int i = 0; i < 8; i++) begin
            drive(t_opc[i], t_f3[i], t_f7[i], 32'h0, 5'd0);
            tick();
            chk($sformatf("dec%0d_bundle", i), bnd(), t_exp[i]);
            chk($sformatf("dec%0d_ctrl_valid", i), 32'(bus.ctrl_valid_o), 32'd1);
        end
        bus.valid_i = 1'b0;
        tick();

        // SRA 0x80000000 by 4, with a new ADD held valid during the shift
        drive(OPC_R, 3'b101, 1'b1, 32'h8000_0000, 5'd4);
        tick();
        chk("sra_bundle", bnd(), 32'h24);
        chk("sra_ctrl_valid", 32'(bus.ctrl_valid_o), 32'd1);
        chk("sra_c1_busy", 32'(bus.busy_o), 32'd1);
        chk("sra_c1_ready", 32'(bus.ready_o), 32'd0);
        drive(OPC_R, 3'b000, 1'b0, 32'h0, 5'd0);
        for (int c = 2; c <= 4; c++) begin
            tick();
            chk($sformatf("sra_c%0d_busy", c), 32'(bus.busy_o), 32'd1);
            chk($sformatf("sra_c%0d_ctrl_valid", c), 32'(bus.ctrl_valid_o), 32'd0);
            chk($sformatf("sra_c%0d_shift_valid", c), 32'(bus.shift_valid_o), 32'd0);
            chk($sformatf("sra_c%0d_bundle", c), bnd(), 32'h24);
        end
        tick();
        chk("sra_c5_shift_valid", 32'(bus.shift_valid_o), 32'd1);
        chk("sra_c5_result", bus.shift_result_o, 32'hF800_0000);
        chk("sra_c5_busy", 32'(bus.busy_o), 32'd1);
        chk("sra_c5_ready", 32'(bus.ready_o), 32'd0);
        chk("sra_c5_ctrl_valid", 32'(bus.ctrl_valid_o), 32'd0);
        tick();
        chk("sra_c6_ready", 32'(bus.ready_o), 32'd1);
        chk("sra_c6_busy", 32'(bus.busy_o), 32'd0);
        chk("sra_c6_shift_valid", 32'(bus.shift_valid_o), 32'd0);
        chk("sra_c6_result_hold", bus.shift_result_o, 32'hF800_0000);
        chk("sra_c6_bundle", bnd(), 32'h24);
        chk("sra_c6_ctrl_valid", 32'(bus.ctrl_valid_o), 32'd0);
        tick();
        chk("held_add_bundle", bnd(), 32'h08);
        chk("held_add_ctrl_valid", 32'(bus.ctrl_valid_o), 32'd1);
        bus.valid_i = 1'b0;
        tick();

        // Shift corner cases: zero amount, maximum amount, fill direction
        run_shift("sll0", 3'b001, 1'b0, 32'h0000_0001, 5'd0, 32'h20, 32'h0000_0001);
        run_shift("srl31", 3'b101, 1'b0, 32'h8000_0000, 5'd31, 32'h1C, 32'h0000_0001);
        run_shift("sll2", 3'b001, 1'b0, 32'hC000_0003, 5'd2, 32'h20, 32'h0000_000C);
        run_shift("srl4", 3'b101, 1'b0, 32'hF000_0000, 5'd4, 32'h1C, 32'h0F00_0000);

        // Illegal opcode
        drive(OPC_BAD, 3'b000, 1'b0, 32'h0, 5'd0);
        tick();
        chk("ill_pulse", 32'(bus.illegal_o), 32'd1);
        chk("ill_bundle", bnd(), 32'h00);
        chk("ill_ctrl_valid", 32'(bus.ctrl_valid_o), 32'd0);
        chk("ill_ready", 32'(bus.ready_o), 32'd1);
        bus.valid_i = 1'b0;
        tick();
        chk("ill_one_cycle", 32'(bus.illegal_o), 32'd0);

        // Reset during cycle 2 of SLL by 10
        drive(OPC_R, 3'b001, 1'b0, 32'h0000_0001, 5'd10);
        tick();
        bus.valid_i = 1'b0;
        chk("rsl_bundle", bnd(), 32'h20);
        tick();
        chk("rsl_busy_before", 32'(bus.busy_o), 32'd1);
        rst_n_i = 1'b0;
        #1;
        chk("rsl_busy", 32'(bus.busy_o), 32'd0);
        chk("rsl_ready", 32'(bus.ready_o), 32'd1);
        chk("rsl_bundle_rst", bnd(), 32'h00);
        chk("rsl_ctrl_valid", 32'(bus.ctrl_valid_o), 32'd0);
        chk("rsl_shift_valid", 32'(bus.shift_valid_o), 32'd0);
        chk("rsl_result", bus.shift_result_o, 32'h0);
        repeat (2) tick();
        rst_n_i = 1'b1;
        seen = 1'b0;
        repeat (16) begin
            tick();
            seen = seen | bus.shift_valid_o;
        end
        chk("rsl_no_shift_valid", 32'(seen), 32'd0);
        chk("rsl_idle_after", 32'(bus.ready_o), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
